execute_stage: RTL

- Execute stage of the 16-bit RISC pipeline. It sits directly downstream of the ID/EX pipeline buffer and consumes its registered outputs.
- Contains the following:
  - operand forwarding from the EX/MEM and MEM/WB stages;
  - the ALU;
  - the condition-code register (Z, N, C);
  - an iterative 16-cycle shift-add multiplier that stalls the front end while it runs;
  - the EX/MEM output register feeding the memory stage.

---
 rtl/execute_stage_pkg.sv | 81 ++++++++
 rtl/execute_stage_mul_iter.sv | 42 ++++
 rtl/execute_stage.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage: widths, ALU opcodes, carry
// encodings, flag indices, multiply FSM states and EX/MEM payloads.
package execute_stage_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned MUL_STEPS = 16;
  localparam int unsigned CNT_W     = $clog2(MUL_STEPS);
  localparam int unsigned SHAMT_W   = 4;
  localparam int unsigned FLAG_W    = 3;
  localparam int unsigned OP_W      = 4;

  localparam logic [OP_W-1:0] ALU_NOP = 4'd0;
  localparam logic [OP_W-1:0] ALU_NOT = 4'd1;
  localparam logic [OP_W-1:0] ALU_INC = 4'd2;
  localparam logic [OP_W-1:0] ALU_DEC = 4'd3;
  localparam logic [OP_W-1:0] ALU_ADD = 4'd4;
  localparam logic [OP_W-1:0] ALU_SUB = 4'd5;
  localparam logic [OP_W-1:0] ALU_AND = 4'd6;
  localparam logic [OP_W-1:0] ALU_OR  = 4'd7;
  localparam logic [OP_W-1:0] ALU_SHL = 4'd8;
  localparam logic [OP_W-1:0] ALU_SHR = 4'd9;
  localparam logic [OP_W-1:0] ALU_MUL = 4'd10;
  localparam logic [OP_W-1:0] ALU_MOV = 4'd11;

  localparam logic [1:0] CF_SET = 2'b01;
  localparam logic [1:0] CF_CLR = 2'b10;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mul_state_e;

  typedef struct packed {
    logic              reg_write;
    logic              mem_or_reg;
    logic              mem_write;
    logic              mem_read;
    logic [ADDR_W-1:0] dest_addr;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
  } exmem_t;

  // Controls of a multiply, held while the iterative datapath runs
  typedef struct packed {
    logic              reg_write;
    logic              mem_or_reg;
    logic              mem_write;
    logic              mem_read;
    logic              update_status;
    logic [1:0]        carry_flag;
    logic [ADDR_W-1:0] dest_addr;
    logic [DATA_W-1:0] store_data;
  } mul_hold_t;

  function automatic logic [FLAG_W-1:0] next_flags(
    input logic [FLAG_W-1:0] cur,
    input logic [DATA_W-1:0] res,
    input logic              zn_en,
    input logic              c_en,
    input logic              c_val,
    input logic [1:0]        carry_flag
  );
    logic [FLAG_W-1:0] nf;
    nf = cur;
    if (zn_en) begin
      nf[FLAG_Z] = (res == '0);
      nf[FLAG_N] = res[DATA_W-1];
    end
    if (c_en) nf[FLAG_C] = c_val;
    // Explicit carry set/clear beats whatever the ALU produced
    if (carry_flag == CF_SET)      nf[FLAG_C] = 1'b1;
    else if (carry_flag == CF_CLR) nf[FLAG_C] = 1'b0;
    return nf;
  endfunction

endpackage

// File: rtl/execute_stage_mul_iter.sv
// Iterative shift-add multiplier: one partial product per step, low DATA_W
// bits kept. product_c_o is the accumulator value after the current step.
module mul_iter
  import execute_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              done_c_o,
  output logic [DATA_W-1:0] product_c_o
);

  logic [DATA_W-1:0] mcand_q, mplier_q, acc_q, acc_d;
  logic [CNT_W-1:0]  count_q;

  assign acc_d       = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign product_c_o = acc_d;
  assign done_c_o    = (count_q == CNT_W'(MUL_STEPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else if (start_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      count_q  <= '0;
    end else if (step_i) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, Z/N/C flags, iterative multiply
// with front-end stall, and the EX/MEM output register.
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              reg_write_i,
  input  logic              mem_or_reg_i,
  input  logic              mem_write_i,
  input  logic              mem_read_i,
  input  logic              imm_or_reg_i,
  input  logic              update_status_i,
  input  logic [OP_W-1:0]   alu_ctrl_i,
  input  logic [1:0]        carry_flag_i,
  input  logic [ADDR_W-1:0] reg_src_addr_i,
  input  logic [ADDR_W-1:0] reg_dest_addr_i,
  input  logic [DATA_W-1:0] reg_src_i,
  input  logic [DATA_W-1:0] reg_dest_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic              exmem_reg_write_i,
  input  logic [ADDR_W-1:0] exmem_dest_addr_i,
  input  logic [DATA_W-1:0] exmem_result_i,
  input  logic              memwb_reg_write_i,
  input  logic [ADDR_W-1:0] memwb_dest_addr_i,
  input  logic [DATA_W-1:0] memwb_result_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] o_alu_result,
  output logic [DATA_W-1:0] o_store_data,
  output logic [ADDR_W-1:0] o_reg_dest_addr,
  output logic              o_reg_write,
  output logic              o_mem_or_reg,
  output logic              o_mem_write,
  output logic              o_mem_read,
  output logic [FLAG_W-1:0] o_flags
);

  mul_state_e        state_q, state_d;
  exmem_t            exmem_q, exmem_d;
  mul_hold_t         hold_q, hold_d;
  logic [FLAG_W-1:0] flags_q, flags_d;

  logic [DATA_W-1:0] op_a, op_b, src_fwd, alu_res, mul_product;
  logic [DATA_W:0]   wide;
  logic              alu_c, alu_c_en, alu_zn_en;
  logic              mul_start, mul_step, mul_done;

  // Forwarding: EX/MEM beats MEM/WB beats the ID/EX value
  always_comb begin
    op_a = reg_dest_i;
    if (exmem_reg_write_i && (exmem_dest_addr_i == reg_dest_addr_i))
      op_a = exmem_result_i;
    else if (memwb_reg_write_i && (memwb_dest_addr_i == reg_dest_addr_i))
      op_a = memwb_result_i;
    src_fwd = reg_src_i;
    if (exmem_reg_write_i && (exmem_dest_addr_i == reg_src_addr_i))
      src_fwd = exmem_result_i;
    else if (memwb_reg_write_i && (memwb_dest_addr_i == reg_src_addr_i))
      src_fwd = memwb_result_i;
    op_b = imm_or_reg_i ? imm_i : src_fwd;
  end

  always_comb begin
    alu_res   = op_a;
    alu_c     = 1'b0;
    alu_c_en  = 1'b0;
    alu_zn_en = 1'b1;
    wide      = '0;
    case (alu_ctrl_i)
      ALU_NOT: alu_res = ~op_a;
      ALU_INC: begin
        wide     = {1'b0, op_a} + (DATA_W + 1)'(1);
        alu_res  = wide[DATA_W-1:0];
        alu_c    = wide[DATA_W];
        alu_c_en = 1'b1;
      end
      ALU_DEC: begin
        wide     = {1'b0, op_a} - (DATA_W + 1)'(1);
        alu_res  = wide[DATA_W-1:0];
        alu_c    = wide[DATA_W];
        alu_c_en = 1'b1;
      end
      ALU_ADD: begin
        wide     = {1'b0, op_a} + {1'b0, op_b};
        alu_res  = wide[DATA_W-1:0];
        alu_c    = wide[DATA_W];
        alu_c_en = 1'b1;
      end
      ALU_SUB: begin
        wide     = {1'b0, op_a} - {1'b0, op_b};
        alu_res  = wide[DATA_W-1:0];
        alu_c    = wide[DATA_W];
        alu_c_en = 1'b1;
      end
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      // Extra bit catches the last bit shifted out; zero shift gives C=0
      ALU_SHL: begin
        wide     = {1'b0, op_a} << op_b[SHAMT_W-1:0];
        alu_res  = wide[DATA_W-1:0];
        alu_c    = wide[DATA_W];
        alu_c_en = 1'b1;
      end
      ALU_SHR: begin
        wide     = {op_a, 1'b0} >> op_b[SHAMT_W-1:0];
        alu_res  = wide[DATA_W:1];
        alu_c    = wide[0];
        alu_c_en = 1'b1;
      end
      ALU_MOV: alu_res = op_b;
      default: alu_zn_en = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    exmem_d   = '0;
    hold_d    = hold_q;
    flags_d   = flags_q;
    stall_o   = 1'b0;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (alu_ctrl_i == ALU_MUL) begin
            stall_o               = 1'b1;
            mul_start             = 1'b1;
            state_d               = ST_BUSY;
            hold_d.reg_write      = reg_write_i;
            hold_d.mem_or_reg     = mem_or_reg_i;
            hold_d.mem_write      = mem_write_i;
            hold_d.mem_read       = mem_read_i;
            hold_d.update_status  = update_status_i;
            hold_d.carry_flag     = carry_flag_i;
            hold_d.dest_addr      = reg_dest_addr_i;
            hold_d.store_data     = op_a;
          end else begin
            exmem_d.reg_write  = reg_write_i;
            exmem_d.mem_or_reg = mem_or_reg_i;
            exmem_d.mem_write  = mem_write_i;
            exmem_d.mem_read   = mem_read_i;
            exmem_d.dest_addr  = reg_dest_addr_i;
            exmem_d.result     = alu_res;
            exmem_d.store_data = op_a;
            flags_d = next_flags(flags_q, alu_res, alu_zn_en && update_status_i,
                                 alu_c_en && update_status_i, alu_c, carry_flag_i);
          end
        end
        ST_BUSY: begin
          mul_step = 1'b1;
          if (mul_done) begin
            state_d            = ST_IDLE;
            exmem_d.reg_write  = hold_q.reg_write;
            exmem_d.mem_or_reg = hold_q.mem_or_reg;
            exmem_d.mem_write  = hold_q.mem_write;
            exmem_d.mem_read   = hold_q.mem_read;
            exmem_d.dest_addr  = hold_q.dest_addr;
            exmem_d.result     = mul_product;
            exmem_d.store_data = hold_q.store_data;
            flags_d = next_flags(flags_q, mul_product, hold_q.update_status,
                                 1'b0, 1'b0, hold_q.carry_flag);
          end else begin
            stall_o = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      exmem_q <= '0;
      hold_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      exmem_q <= exmem_d;
      hold_q  <= hold_d;
      flags_q <= flags_d;
    end
  end

  mul_iter u_mul_iter (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (mul_start),
    .step_i      (mul_step),
    .a_i         (op_a),
    .b_i         (op_b),
    .done_c_o    (mul_done),
    .product_c_o (mul_product)
  );

  assign o_alu_result    = exmem_q.result;
  assign o_store_data    = exmem_q.store_data;
  assign o_reg_dest_addr = exmem_q.dest_addr;
  assign o_reg_write     = exmem_q.reg_write;
  assign o_mem_or_reg    = exmem_q.mem_or_reg;
  assign o_mem_write     = exmem_q.mem_write;
  assign o_mem_read      = exmem_q.mem_read;
  assign o_flags         = flags_q;

endmodule
